// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, instruction field
// positions, ID/EX bundle widths and the opcode decoder.
package pipe_pkg;

    localparam int OP_W  = 4;
    localparam int IMM_W = 6;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd5;
    localparam logic [OP_W-1:0] OP_LD   = 4'd6;
    localparam logic [OP_W-1:0] OP_ST   = 4'd7;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic legal;
        logic use1;
        logic use2;
        logic wen;
        logic is_load;
        logic is_store;
    } dec_t;

    // Opcodes 8-15 leave everything clear, i.e. an illegal NOP.
    function automatic dec_t decode(input logic [OP_W-1:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_NOP: d.legal = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                d.legal = 1'b1;
                d.use1  = 1'b1;
                d.use2  = 1'b1;
                d.wen   = 1'b1;
            end
            OP_ADDI: begin
                d.legal = 1'b1;
                d.use1  = 1'b1;
                d.wen   = 1'b1;
            end
            OP_LD: begin
                d.legal   = 1'b1;
                d.use1    = 1'b1;
                d.wen     = 1'b1;
                d.is_load = 1'b1;
            end
            OP_ST: begin
                d.legal    = 1'b1;
                d.use1     = 1'b1;
                d.use2     = 1'b1;
                d.is_store = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_bypass_mux.sv
// Operand select for one source register. With ID_FWD_EN: EX/MEM/WB bypass and
// load-use hazard; without it: register file only, hazard on any pending write.
module id_bypass_mux #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 2
) (
    input  logic             i_use,
    input  logic [ADDR-1:0]  i_rs,
    input  logic             i_ex_wen,
    input  logic             i_ex_is_load,
    input  logic [ADDR-1:0]  i_ex_rd,
    input  logic [WIDTH-1:0] i_ex_result,
    input  logic             i_mem_wen,
    input  logic [ADDR-1:0]  i_mem_rd,
    input  logic [WIDTH-1:0] i_mem_result,
    input  logic             i_wb_wen,
    input  logic [ADDR-1:0]  i_wb_rd,
    input  logic [WIDTH-1:0] i_wb_data,
    input  logic [WIDTH-1:0] i_rf_data,
    output logic [WIDTH-1:0] o_opnd,
    output logic             o_hazard
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_ex_hit  = i_ex_wen  && (i_ex_rd  == i_rs);
    assign w_mem_hit = i_mem_wen && (i_mem_rd == i_rs);
    assign w_wb_hit  = i_wb_wen  && (i_wb_rd  == i_rs);

`ifdef ID_FWD_EN
    // WB bypass also covers the rf returning stale data during a same-cycle write.
    always_comb begin
        o_opnd = '0;
        if (i_use) begin
            if (w_ex_hit && !i_ex_is_load) o_opnd = i_ex_result;
            else if (w_mem_hit)            o_opnd = i_mem_result;
            else if (w_wb_hit)             o_opnd = i_wb_data;
            else                           o_opnd = i_rf_data;
        end
    end

    assign o_hazard = i_use && w_ex_hit && i_ex_is_load;
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{i_ex_is_load, i_ex_result, i_mem_result, i_wb_data};
    assign o_opnd       = i_use ? i_rf_data : '0;
    assign o_hazard     = i_use && (w_ex_hit || w_mem_hit || w_wb_hit);
`endif

endmodule

// File: rtl/id_stage.sv
// Decode/operand-fetch stage; 1-cycle latency into the ID/EX register. Build option ID_FWD_EN.
// Backpressure: id_ready drops combinationally on a source hazard; IF must hold if_instr.
module id_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ADDR  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [15:0]      if_instr,
    output logic             id_ready,
    input  logic             flush,
    output logic             rf_r1_en,
    output logic             rf_r2_en,
    output logic [ADDR-1:0]  rf_r1_addr,
    output logic [ADDR-1:0]  rf_r2_addr,
    input  logic [WIDTH-1:0] rf_r1_data,
    input  logic [WIDTH-1:0] rf_r2_data,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic [ADDR-1:0]  ex_rd,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             mem_wen,
    input  logic [ADDR-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_wen,
    input  logic [ADDR-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             idex_valid,
    output logic [OP_W-1:0]  idex_op,
    output logic [ADDR-1:0]  idex_rd,
    output logic             idex_wen,
    output logic             idex_is_load,
    output logic             idex_is_store,
    output logic [WIDTH-1:0] idex_a,
    output logic [WIDTH-1:0] idex_b,
    output logic [WIDTH-1:0] idex_imm
);

    logic [OP_W-1:0]  w_op;
    logic [ADDR-1:0]  w_rd;
    logic [ADDR-1:0]  w_rs1;
    logic [ADDR-1:0]  w_rs2;
    logic [IMM_W-1:0] w_imm;
    dec_t             w_dec;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_hz1;
    logic             w_hz2;
    logic             w_transfer;
    logic             w_issue;

    logic             r_valid;
    logic [OP_W-1:0]  r_op;
    logic [ADDR-1:0]  r_rd;
    logic             r_wen;
    logic             r_is_load;
    logic             r_is_store;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_imm;

    assign w_op  = if_instr[OP_MSB:OP_LSB];
    assign w_rd  = if_instr[RD_MSB:RD_LSB];
    assign w_rs1 = if_instr[RS1_MSB:RS1_LSB];
    assign w_rs2 = if_instr[RS2_MSB:RS2_LSB];
    assign w_imm = if_instr[IMM_MSB:IMM_LSB];
    assign w_dec = decode(w_op);

    assign rf_r1_en   = if_valid && w_dec.use1;
    assign rf_r2_en   = if_valid && w_dec.use2;
    assign rf_r1_addr = w_rs1;
    assign rf_r2_addr = w_rs2;

    id_bypass_mux #(.WIDTH(WIDTH), .ADDR(ADDR)) u_mux_a (
        .i_use        (w_dec.use1),
        .i_rs         (w_rs1),
        .i_ex_wen     (ex_wen),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_ex_result  (ex_result),
        .i_mem_wen    (mem_wen),
        .i_mem_rd     (mem_rd),
        .i_mem_result (mem_result),
        .i_wb_wen     (wb_wen),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .i_rf_data    (rf_r1_data),
        .o_opnd       (w_a),
        .o_hazard     (w_hz1)
    );

    id_bypass_mux #(.WIDTH(WIDTH), .ADDR(ADDR)) u_mux_b (
        .i_use        (w_dec.use2),
        .i_rs         (w_rs2),
        .i_ex_wen     (ex_wen),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_ex_result  (ex_result),
        .i_mem_wen    (mem_wen),
        .i_mem_rd     (mem_rd),
        .i_mem_result (mem_result),
        .i_wb_wen     (wb_wen),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .i_rf_data    (rf_r2_data),
        .o_opnd       (w_b),
        .o_hazard     (w_hz2)
    );

    // Flush does not touch id_ready; IF drops the instruction itself on redirect.
    assign id_ready   = !(if_valid && (w_hz1 || w_hz2));
    assign w_transfer = if_valid && id_ready;
    assign w_issue    = w_transfer && w_dec.legal && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_op       <= '0;
            r_rd       <= '0;
            r_wen      <= 1'b0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
        end else begin
            r_valid    <= w_issue;
            r_wen      <= w_issue && w_dec.wen;
            r_is_load  <= w_issue && w_dec.is_load;
            r_is_store <= w_issue && w_dec.is_store;
            if (w_transfer) begin
                r_op  <= w_dec.legal ? w_op : OP_NOP;
                r_rd  <= w_rd;
                r_a   <= w_a;
                r_b   <= w_b;
                r_imm <= {{(WIDTH-IMM_W){w_imm[IMM_W-1]}}, w_imm};
            end
        end
    end

    assign idex_valid    = r_valid;
    assign idex_op       = r_op;
    assign idex_rd       = r_rd;
    assign idex_wen      = r_wen;
    assign idex_is_load  = r_is_load;
    assign idex_is_store = r_is_store;
    assign idex_a        = r_a;
    assign idex_b        = r_b;
    assign idex_imm      = r_imm;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage; expectations switch on ID_FWD_EN to match the build.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        id_ready;
    logic        flush;
    logic        rf_r1_en, rf_r2_en;
    logic [1:0]  rf_r1_addr, rf_r2_addr;
    logic [15:0] rf_r1_data, rf_r2_data;
    logic        ex_wen, ex_is_load;
    logic [1:0]  ex_rd;
    logic [15:0] ex_result;
    logic        mem_wen;
    logic [1:0]  mem_rd;
    logic [15:0] mem_result;
    logic        wb_wen;
    logic [1:0]  wb_rd;
    logic [15:0] wb_data;
    logic        idex_valid;
    logic [3:0]  idex_op;
    logic [1:0]  idex_rd;
    logic        idex_wen, idex_is_load, idex_is_store;
    logic [15:0] idex_a, idex_b, idex_imm;

    logic [15:0] rf [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_r1_data = rf[rf_r1_addr];
    assign rf_r2_data = rf[rf_r2_addr];

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
        .flush(flush), .rf_r1_en(rf_r1_en), .rf_r2_en(rf_r2_en),
        .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
        .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .idex_valid(idex_valid), .idex_op(idex_op), .idex_rd(idex_rd), .idex_wen(idex_wen),
        .idex_is_load(idex_is_load), .idex_is_store(idex_is_store),
        .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 0; if_instr = 16'h0; flush = 0;
        ex_wen = 0; ex_is_load = 0; ex_rd = 0; ex_result = 16'h0;
        mem_wen = 0; mem_rd = 0; mem_result = 16'h0;
        wb_wen = 0; wb_rd = 0; wb_data = 16'h0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #12;
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", idex_valid); end
        checks++; if ({idex_op, idex_rd, idex_wen, idex_is_load, idex_is_store} !== 9'h0) begin errors++; $display("FAIL reset_ctrl: got %h exp 0", {idex_op, idex_rd, idex_wen, idex_is_load, idex_is_store}); end
        checks++; if ({idex_a, idex_b, idex_imm} !== 48'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", {idex_a, idex_b, idex_imm}); end
        @(negedge clk);
        rst = 0;
        step();
    endtask

    // ADD r1,r2,r3 with no pending writes anywhere.
    task automatic test_add();
        idle();
        if_valid = 1; if_instr = 16'h16C0;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b exp 1", id_ready); end
        checks++; if ({rf_r1_en, rf_r2_en, rf_r1_addr, rf_r2_addr} !== 6'b11_10_11) begin errors++; $display("FAIL add_rfport: got %b exp 111011", {rf_r1_en, rf_r2_en, rf_r1_addr, rf_r2_addr}); end
        step();
        checks++; if ({idex_valid, idex_op, idex_rd, idex_wen, idex_is_load, idex_is_store} !== 10'b1_0001_01_1_0_0) begin errors++; $display("FAIL add_ctrl: got %b exp 1000101100", {idex_valid, idex_op, idex_rd, idex_wen, idex_is_load, idex_is_store}); end
        checks++; if ({idex_a, idex_b} !== {16'h0005, 16'h0007}) begin errors++; $display("FAIL add_opnd: got %h exp 00050007", {idex_a, idex_b}); end
    endtask

    // ADD r1,r1,r2 with EX and MEM both targeting r1.
    task automatic test_ex_priority();
        idle();
        if_valid = 1; if_instr = 16'h1580;
        ex_wen = 1; ex_rd = 1; ex_result = 16'h0010;
        mem_wen = 1; mem_rd = 1; mem_result = 16'h0020;
        #1;
`ifdef ID_FWD_EN
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL exprio_ready: got %b exp 1", id_ready); end
        step();
        checks++; if ({idex_valid, idex_a, idex_b} !== {1'b1, 16'h0010, 16'h0005}) begin errors++; $display("FAIL exprio_opnd: got %h exp 1_0010_0005", {idex_valid, idex_a, idex_b}); end
`else
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL exprio_ready: got %b exp 0", id_ready); end
        step();
        checks++; if ({idex_valid, idex_wen} !== 2'b00) begin errors++; $display("FAIL exprio_bubble: got %b exp 00", {idex_valid, idex_wen}); end
        ex_wen = 0; mem_wen = 0;
        step();
        checks++; if ({idex_valid, idex_a, idex_b} !== {1'b1, 16'h0099, 16'h0005}) begin errors++; $display("FAIL exprio_opnd: got %h exp 1_0099_0005", {idex_valid, idex_a, idex_b}); end
`endif
    endtask

    // LD r2 in EX, then SUB r3,r2,r0; load data arrives via MEM next cycle.
    task automatic test_load_use();
        idle();
        if_valid = 1; if_instr = 16'h2E00;
        ex_wen = 1; ex_is_load = 1; ex_rd = 2; ex_result = 16'hDEAD;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lduse_ready: got %b exp 0", id_ready); end
        step();
        checks++; if ({idex_valid, idex_wen, idex_is_load, idex_is_store} !== 4'b0000) begin errors++; $display("FAIL lduse_bubble: got %b exp 0000", {idex_valid, idex_wen, idex_is_load, idex_is_store}); end
        ex_wen = 0; ex_is_load = 0;
        mem_wen = 1; mem_rd = 2; mem_result = 16'h1234;
        #1;
`ifdef ID_FWD_EN
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lduse_resume: got %b exp 1", id_ready); end
        step();
        checks++; if ({idex_valid, idex_op, idex_a, idex_b} !== {1'b1, 4'h2, 16'h1234, 16'h000A}) begin errors++; $display("FAIL lduse_opnd: got %h exp 1_2_1234_000a", {idex_valid, idex_op, idex_a, idex_b}); end
`else
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lduse_resume: got %b exp 0", id_ready); end
        step();
        mem_wen = 0;
        step();
        checks++; if ({idex_valid, idex_op, idex_a, idex_b} !== {1'b1, 4'h2, 16'h0005, 16'h000A}) begin errors++; $display("FAIL lduse_opnd: got %h exp 1_2_0005_000a", {idex_valid, idex_op, idex_a, idex_b}); end
`endif
    endtask

    // ADDI r0,r1,-2 then LD r2,[r3+1].
    task automatic test_imm();
        idle();
        if_valid = 1; if_instr = 16'h513E;
        #1;
        checks++; if ({rf_r1_en, rf_r2_en, rf_r2_addr} !== 4'b10_00) begin errors++; $display("FAIL addi_rfport: got %b exp 1000", {rf_r1_en, rf_r2_en, rf_r2_addr}); end
        step();
        checks++; if ({idex_valid, idex_op, idex_rd, idex_wen} !== 8'b1_0101_00_1) begin errors++; $display("FAIL addi_ctrl: got %b exp 10101001", {idex_valid, idex_op, idex_rd, idex_wen}); end
        checks++; if ({idex_imm, idex_a, idex_b} !== {16'hFFFE, 16'h0099, 16'h0000}) begin errors++; $display("FAIL addi_data: got %h exp fffe_0099_0000", {idex_imm, idex_a, idex_b}); end
        if_instr = 16'h6B01;
        step();
        checks++; if ({idex_valid, idex_wen, idex_is_load, idex_is_store, idex_rd} !== 6'b1110_10) begin errors++; $display("FAIL ld_ctrl: got %b exp 111010", {idex_valid, idex_wen, idex_is_load, idex_is_store, idex_rd}); end
        checks++; if ({idex_imm, idex_a, idex_b} !== {16'h0001, 16'h0007, 16'h0000}) begin errors++; $display("FAIL ld_data: got %h exp 0001_0007_0000", {idex_imm, idex_a, idex_b}); end
    endtask

    // ST killed by flush, then the same ST taken, then an illegal opcode.
    task automatic test_flush_illegal();
        idle();
        if_valid = 1; if_instr = 16'h7183; flush = 1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", id_ready); end
        step();
        checks++; if ({idex_valid, idex_is_store, idex_wen} !== 3'b000) begin errors++; $display("FAIL flush_kill: got %b exp 000", {idex_valid, idex_is_store, idex_wen}); end
        flush = 0;
        step();
        checks++; if ({idex_valid, idex_is_store, idex_wen, idex_is_load} !== 4'b1100) begin errors++; $display("FAIL st_ctrl: got %b exp 1100", {idex_valid, idex_is_store, idex_wen, idex_is_load}); end
        checks++; if ({idex_a, idex_b, idex_imm} !== {16'h0099, 16'h0005, 16'h0003}) begin errors++; $display("FAIL st_data: got %h exp 0099_0005_0003", {idex_a, idex_b, idex_imm}); end
        if_instr = 16'hC6C0;
        step();
        checks++; if ({idex_valid, idex_wen, idex_is_load, idex_is_store} !== 4'b0000) begin errors++; $display("FAIL illegal: got %b exp 0000", {idex_valid, idex_wen, idex_is_load, idex_is_store}); end
    endtask

    // No instruction presented: no reads, no stall even with a load in EX.
    task automatic test_idle_if();
        idle();
        if_instr = 16'h2E00; ex_wen = 1; ex_is_load = 1; ex_rd = 2;
        #1;
        checks++; if ({id_ready, rf_r1_en, rf_r2_en} !== 3'b100) begin errors++; $display("FAIL idle_ports: got %b exp 100", {id_ready, rf_r1_en, rf_r2_en}); end
        step();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b exp 0", idex_valid); end
    endtask

    // ADD r2,r1,r3 while WB writes r1.
    task automatic test_wb_dep();
        idle();
        if_valid = 1; if_instr = 16'h19C0;
        wb_wen = 1; wb_rd = 1; wb_data = 16'h0BEE;
        #1;
`ifdef ID_FWD_EN
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL wb_ready: got %b exp 1", id_ready); end
        mem_wen = 1; mem_rd = 3; mem_result = 16'h0303;
        step();
        checks++; if ({idex_valid, idex_a, idex_b} !== {1'b1, 16'h0BEE, 16'h0303}) begin errors++; $display("FAIL wb_opnd: got %h exp 1_0bee_0303", {idex_valid, idex_a, idex_b}); end
`else
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL wb_ready: got %b exp 0", id_ready); end
        step();
        checks++; if ({idex_valid, id_ready} !== 2'b00) begin errors++; $display("FAIL wb_hold: got %b exp 00", {idex_valid, id_ready}); end
        wb_wen = 0;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL wb_release: got %b exp 1", id_ready); end
        step();
        checks++; if ({idex_valid, idex_a, idex_b} !== {1'b1, 16'h0099, 16'h0007}) begin errors++; $display("FAIL wb_opnd: got %h exp 1_0099_0007", {idex_valid, idex_a, idex_b}); end
`endif
    endtask

    // Back-to-back issue, then asynchronous reset in the middle of a stall.
    task automatic test_back_to_back_reset();
        idle();
        if_valid = 1; if_instr = 16'h16C0;
        step();
        if_instr = 16'h2E00;
        step();
        checks++; if ({idex_valid, idex_op, idex_rd, idex_a, idex_b} !== {1'b1, 4'h2, 2'd3, 16'h0005, 16'h000A}) begin errors++; $display("FAIL b2b_second: got %h exp b_0005_000a", {idex_valid, idex_op, idex_rd, idex_a, idex_b}); end
        ex_wen = 1; ex_is_load = 1; ex_rd = 0;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", id_ready); end
        rst = 1; ex_wen = 0; ex_is_load = 0;
        #1;
        checks++; if ({idex_valid, idex_op, idex_a, idex_b} !== 37'h0) begin errors++; $display("FAIL rst_async: got %h exp 0", {idex_valid, idex_op, idex_a, idex_b}); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", id_ready); end
        @(negedge clk);
        rst = 0;
        step();
        checks++; if ({idex_valid, idex_a, idex_b} !== {1'b1, 16'h0005, 16'h000A}) begin errors++; $display("FAIL rst_resume: got %h exp 1_0005_000a", {idex_valid, idex_a, idex_b}); end
    endtask

    initial begin
        rf[0] = 16'h000A; rf[1] = 16'h0099; rf[2] = 16'h0005; rf[3] = 16'h0007;
        test_reset();
        test_add();
        test_ex_priority();
        test_load_use();
        test_imm();
        test_flush_illegal();
        test_idle_if();
        test_wb_dep();
        test_back_to_back_reset();
        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
